imm_fetch_unit: RTL and testbench
=================================

Name: imm_fetch_unit

Overview:
- Parametrised, registered successor to the combinational immediate extractor of the MicroUAZ8 datapath.
- Sits between instruction fetch and the ALU operand mux.
- Produces an immediate operand in one of four formats:
  - short field, zero-extended
  - short field, sign-extended
  - one trailing extension word
  - two trailing extension words, concatenated
- Handles multi-word immediates with a small FSM and a valid/busy handshake toward the fetch stage.

Parameters:
- n, 8, instruction/data word width in bits.
- FIELD_W, 3, width of the short immediate field, taken from i_Instruction[FIELD_W-1:0]; legal range 1..n.
- OUT_W, 2*n, output immediate width; fixed at 2*n, not to be overridden.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_valid  input  1  i_Instruction carries a valid word this cycle.
- i_Instruction  input  n  instruction word or extension word.
- i_mode  input  2  immediate format; sampled only when an instruction is accepted in IDLE.
  - 00 short zero-extend
  - 01 short sign-extend
  - 10 one extension word
  - 11 two extension words
- i_flush  input  1  abort any pending immediate (branch taken).
- o_NUM  output  OUT_W  assembled immediate.
- o_valid  output  1  single-cycle pulse: o_NUM updated this cycle.
- o_busy  output  1  high while waiting for extension words; fetch must route the next words here.

Behaviour:
- Reset (asynchronous, any time, including mid-sequence):
  - state=IDLE, o_NUM=0, o_valid=0, o_busy=0, low-word holding register=0.
- States: IDLE, EXT1, EXT2. o_busy = (state != IDLE), registered with the state.
- o_valid defaults to 0 every cycle. o_NUM holds its last value when o_valid=0.
- IDLE, i_valid=1:
  - mode 00: o_NUM <= zero-extend of i_Instruction[FIELD_W-1:0] to OUT_W; o_valid<=1; stay IDLE.
  - mode 01: o_NUM <= sign-extend of the same field, with bit FIELD_W-1 as the sign; o_valid<=1; stay IDLE.
  - mode 10 or 11: latch the mode into mode_r; go to EXT1; o_NUM unchanged. The opcode word itself carries no immediate bits.
- EXT1, i_valid=1:
  - mode_r=10: o_NUM <= {n zeros, i_Instruction}; o_valid<=1; go to IDLE.
  - mode_r=11: lo_r <= i_Instruction; go to EXT2.
- EXT2, i_valid=1: o_NUM <= {i_Instruction, lo_r} (little-endian, first extension word is low); o_valid<=1; go to IDLE.
- EXT1/EXT2, i_valid=0: hold state and all registers (fetch stall).
- Latency: o_valid asserts in the cycle after the clock edge that accepts the final word of the immediate.
  - 1 cycle for short formats.
  - 1 cycle after the final extension word for long formats.
- Back-to-back: in IDLE, consecutive valid short instructions each produce o_valid on consecutive cycles. No bubble.
- i_flush:
  - Highest priority below reset.
  - When asserted, next state=IDLE, o_valid<=0, o_NUM unchanged, lo_r unchanged.
  - A word presented in the same cycle as i_flush is discarded, in any state.
- i_mode is ignored outside IDLE. Changing it mid-sequence has no effect.
- Width rule: all extensions are computed at OUT_W. Bits above the field are 0 (zero-extend) or a copy of the field MSB (sign-extend).

Decomposition:
- Shared package (imm_pkg):
  - mode encodings: IMM_ZX=2'b00, IMM_SX=2'b01, IMM_EXT1=2'b10, IMM_EXT2=2'b11
  - state encoding: S_IDLE, S_EXT1, S_EXT2
  - default widths N_DEF=8, FIELD_W_DEF=3
- One natural sub-module: imm_extend. It is purely combinational, takes the field, n, FIELD_W, OUT_W and a signed flag, and returns the extended value. It is reused later by the branch-offset path.
- FSM and registers stay in imm_fetch_unit.

Test Plan:
- Reset mid-sequence: i_mode=11, i_Instruction=0xC0, then 0x34, then assert i_rst while in EXT2 -> o_busy=0, o_NUM=0x0000, o_valid=0 asynchronously. The next short instruction works normally.
- Short formats, n=8, FIELD_W=3:
  - i_Instruction=0xA5 (field 3'b101), mode 00 -> o_NUM=0x0005, o_valid pulse 1 cycle later.
  - Same word, mode 01 -> o_NUM=0xFFFD.
- One-extension word: mode 10, word 0x80, then 0x7E with i_valid low for 2 cycles in between -> o_busy high 3 cycles, o_NUM=0x007E, single o_valid pulse.
- Two-extension words: mode 11, 0xC0, 0x34, 0x12 -> o_NUM=0x1234, o_valid one cycle after 0x12 is accepted, o_busy low on the same cycle.
- Flush: mode 11, 0xC0, 0x34, then i_flush=1 with i_valid=1 and 0x12 -> no o_valid, o_NUM keeps its previous value, state IDLE. The following 0x07 in mode 00 -> o_NUM=0x0007.
- Back-to-back shorts: four valid words 0x01, 0x02, 0x03, 0x04 in mode 00 on consecutive cycles -> four consecutive o_valid pulses, o_NUM=0x0001..0x0004.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared encodings and default widths for the immediate fetch path.
// The branch-offset path reuses these encodings as well.
package imm_pkg;

  localparam int N_DEF       = 8;
  localparam int FIELD_W_DEF = 3;

  typedef enum logic [1:0] {
    IMM_ZX   = 2'b00,
    IMM_SX   = 2'b01,
    IMM_EXT1 = 2'b10,
    IMM_EXT2 = 2'b11
  } imm_mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXT1 = 2'b01,
    S_EXT2 = 2'b10
  } imm_state_e;

endpackage

// File: rtl/imm_extend.sv
// Combinational zero/sign extension of a short immediate field to OUT_W bits.
// Shared by the immediate fetch unit and the branch-offset path.
module imm_extend #(
  parameter int N       = 8,
  parameter int FIELD_W = 3,
  parameter int OUT_W   = 2*N
) (
  input  logic [FIELD_W-1:0] field_i,
  input  logic               signed_i,
  output logic [OUT_W-1:0]   ext_o
);

  // The field must fit in one word, and the output must cover at least one word.
  if (FIELD_W < 1 || FIELD_W > N || OUT_W < N) begin : g_bad_params
    $error("imm_extend: illegal FIELD_W/N/OUT_W combination");
  end

  logic fill;

  always_comb begin
    fill  = signed_i & field_i[FIELD_W-1];
    ext_o = {{(OUT_W-FIELD_W){fill}}, field_i};
  end

endmodule

// File: rtl/imm_fetch_unit.sv
// Registered immediate extractor: short fields are extended in place, long
// immediates are assembled from one or two trailing extension words.
module imm_fetch_unit
  import imm_pkg::*;
#(
  parameter int n       = N_DEF,
  parameter int FIELD_W = FIELD_W_DEF,
  parameter int OUT_W   = 2*n
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [n-1:0]     i_Instruction,
  input  logic [1:0]       i_mode,
  input  logic             i_flush,
  output logic [OUT_W-1:0] o_NUM,
  output logic             o_valid,
  output logic             o_busy
);

  if (OUT_W != 2*n) begin : g_bad_out_w
    $error("imm_fetch_unit: OUT_W must equal 2*n");
  end

  imm_state_e       state_q;
  imm_mode_e        mode_q;
  logic [n-1:0]     lo_q;
  logic [OUT_W-1:0] num_q;
  logic             valid_q;
  logic             busy_q;
  logic [OUT_W-1:0] ext_d;

  imm_extend #(
    .N       (n),
    .FIELD_W (FIELD_W),
    .OUT_W   (OUT_W)
  ) u_ext (
    .field_i  (i_Instruction[FIELD_W-1:0]),
    .signed_i (i_mode == IMM_SX),
    .ext_o    (ext_d)
  );

  // Flush beats any word presented in the same cycle; a stalled sequence
  // (i_valid low in EXT1/EXT2) simply holds every register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      mode_q  <= IMM_ZX;
      lo_q    <= '0;
      num_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (i_flush) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else if (i_valid) begin
        case (state_q)
          S_IDLE: begin
            case (imm_mode_e'(i_mode))
              IMM_ZX, IMM_SX: begin
                num_q   <= ext_d;
                valid_q <= 1'b1;
              end
              default: begin
                mode_q  <= imm_mode_e'(i_mode);
                state_q <= S_EXT1;
                busy_q  <= 1'b1;
              end
            endcase
          end
          S_EXT1: begin
            if (mode_q == IMM_EXT1) begin
              num_q   <= {{n{1'b0}}, i_Instruction};
              valid_q <= 1'b1;
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              lo_q    <= i_Instruction;
              state_q <= S_EXT2;
            end
          end
          S_EXT2: begin
            // First extension word is the low half.
            num_q   <= {i_Instruction, lo_q};
            valid_q <= 1'b1;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_NUM   = num_q;
  assign o_valid = valid_q;
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_imm_fetch_unit.sv
// Directed bench for imm_fetch_unit (n=8, FIELD_W=3) with hand-computed expectations.
module tb_imm_fetch_unit;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic [7:0]  i_Instruction;
  logic [1:0]  i_mode;
  logic        i_flush;
  logic [15:0] o_NUM;
  logic        o_valid;
  logic        o_busy;

  int n_chk  = 0;
  int n_fail = 0;

  imm_fetch_unit #(.n(8), .FIELD_W(3)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_valid       (i_valid),
    .i_Instruction (i_Instruction),
    .i_mode        (i_mode),
    .i_flush       (i_flush),
    .o_NUM         (o_NUM),
    .o_valid       (o_valid),
    .o_busy        (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [7:0] w, input logic f);
    i_valid       = v;
    i_mode        = m;
    i_Instruction = w;
    i_flush       = f;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic b, input logic [15:0] num);
    chk({tag, ".valid"}, 32'(o_valid), 32'(v));
    chk({tag, ".busy"},  32'(o_busy),  32'(b));
    chk({tag, ".num"},   32'(o_NUM),   32'(num));
  endtask

  initial begin
    logic [15:0] bb_exp [4];
    bb_exp[0] = 16'h0001; bb_exp[1] = 16'h0002; bb_exp[2] = 16'h0003; bb_exp[3] = 16'h0004;

    i_rst = 1'b1;
    drive(1'b0, 2'b00, 8'h00, 1'b0);
    #3;
    expect_out("reset", 1'b0, 1'b0, 16'h0000);
    tick();
    i_rst = 1'b0;

    // Short zero-extend, then hold with i_valid low
    drive(1'b1, 2'b00, 8'hA5, 1'b0); tick();
    expect_out("zx_a5", 1'b1, 1'b0, 16'h0005);
    drive(1'b0, 2'b00, 8'h00, 1'b0); tick();
    expect_out("zx_hold", 1'b0, 1'b0, 16'h0005);

    // Short sign-extend: negative, positive and most-negative fields
    drive(1'b1, 2'b01, 8'hA5, 1'b0); tick();
    expect_out("sx_a5", 1'b1, 1'b0, 16'hFFFD);
    drive(1'b1, 2'b01, 8'hFB, 1'b0); tick();
    expect_out("sx_fb", 1'b1, 1'b0, 16'h0003);
    drive(1'b1, 2'b01, 8'h04, 1'b0); tick();
    expect_out("sx_04", 1'b1, 1'b0, 16'hFFFC);
    drive(1'b1, 2'b00, 8'hFF, 1'b0); tick();
    expect_out("zx_ff", 1'b1, 1'b0, 16'h0007);

    // One extension word with a two-cycle stall; mode changes mid-sequence ignored
    drive(1'b1, 2'b10, 8'h80, 1'b0); tick();
    expect_out("e1_op", 1'b0, 1'b1, 16'h0007);
    drive(1'b0, 2'b00, 8'h55, 1'b0); tick();
    expect_out("e1_stall1", 1'b0, 1'b1, 16'h0007);
    drive(1'b0, 2'b01, 8'h66, 1'b0); tick();
    expect_out("e1_stall2", 1'b0, 1'b1, 16'h0007);
    drive(1'b1, 2'b00, 8'h7E, 1'b0); tick();
    expect_out("e1_word", 1'b1, 1'b0, 16'h007E);
    drive(1'b0, 2'b00, 8'h00, 1'b0); tick();
    expect_out("e1_after", 1'b0, 1'b0, 16'h007E);

    // Two extension words, little-endian
    drive(1'b1, 2'b11, 8'hC0, 1'b0); tick();
    expect_out("e2_op", 1'b0, 1'b1, 16'h007E);
    drive(1'b1, 2'b00, 8'h34, 1'b0); tick();
    expect_out("e2_lo", 1'b0, 1'b1, 16'h007E);
    drive(1'b1, 2'b01, 8'h12, 1'b0); tick();
    expect_out("e2_hi", 1'b1, 1'b0, 16'h1234);

    // Flush in EXT2 with a word present: word discarded
    drive(1'b1, 2'b11, 8'hC0, 1'b0); tick();
    drive(1'b1, 2'b11, 8'h34, 1'b0); tick();
    expect_out("fl_pre", 1'b0, 1'b1, 16'h1234);
    drive(1'b1, 2'b11, 8'h12, 1'b1); tick();
    expect_out("fl_ext2", 1'b0, 1'b0, 16'h1234);
    drive(1'b1, 2'b00, 8'h07, 1'b0); tick();
    expect_out("fl_next", 1'b1, 1'b0, 16'h0007);

    // Flush in EXT1, and flush of a short word in IDLE
    drive(1'b1, 2'b10, 8'h80, 1'b0); tick();
    drive(1'b1, 2'b10, 8'h99, 1'b1); tick();
    expect_out("fl_ext1", 1'b0, 1'b0, 16'h0007);
    drive(1'b1, 2'b00, 8'h05, 1'b1); tick();
    expect_out("fl_idle", 1'b0, 1'b0, 16'h0007);

    // Back-to-back short words
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'b00, 8'(k + 1), 1'b0); tick();
      expect_out($sformatf("b2b_%0d", k), 1'b1, 1'b0, bb_exp[k]);
    end

    // Asynchronous reset while in EXT2
    drive(1'b1, 2'b11, 8'hC0, 1'b0); tick();
    drive(1'b1, 2'b11, 8'h34, 1'b0); tick();
    expect_out("rst_pre", 1'b0, 1'b1, 16'h0004);
    drive(1'b0, 2'b00, 8'h00, 1'b0);
    #2 i_rst = 1'b1;
    #1;
    expect_out("rst_mid", 1'b0, 1'b0, 16'h0000);
    tick();
    i_rst = 1'b0;
    drive(1'b1, 2'b00, 8'h06, 1'b0); tick();
    expect_out("rst_next", 1'b1, 1'b0, 16'h0006);
    // A stale low word must not leak: next long immediate starts fresh
    drive(1'b1, 2'b11, 8'hC0, 1'b0); tick();
    drive(1'b1, 2'b11, 8'hAB, 1'b0); tick();
    drive(1'b1, 2'b11, 8'hCD, 1'b0); tick();
    expect_out("e2_again", 1'b1, 1'b0, 16'hCDAB);

    drive(1'b0, 2'b00, 8'h00, 1'b0); tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
